// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default 640x480 geometry, line/frame total helpers and the sync bundle type
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Pixel divider counter width; covers divide ratios up to 16
    localparam int DIV_W = 4;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// pixel_tick_div: divides clk by PIX_DIV into a one-cycle pixel tick, frozen while en_i is low
module pixel_tick_div
    import video_timing_pkg::*;
#(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             wrap;

    // Count phase; the tick is held rather than cleared while disabled so a pending pixel survives a freeze
    always_comb begin
        wrap   = div_q == DIV_LAST;
        div_d  = !en_i ? div_q : wrap ? '0 : div_q + DIV_W'(1);
        tick_d = en_i ? wrap : tick_q;
    end

    // Divider phase and tick registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q & en_i;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing (tick, col/row, syncs, de, frame address, line/frame pulses)
// Optional frame counter output enabled by defining VTG_FRAME_CNT_EN.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   CNT_W    = 10,
    parameter int   ADDR_W   = 20,
    parameter int   PIX_DIV  = 2,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
    output logic              pixel_tick,
    output logic [CNT_W-1:0]  col,
    output logic [CNT_W-1:0]  row,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [ADDR_W-1:0] addr,
    output logic              line_end,
    output logic              frame_end
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic              tick;
    logic              h_wrap, v_wrap;
    logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    sync_t             sync_q, sync_d;

    pixel_tick_div #(
        .PIX_DIV(PIX_DIV)
    ) u_div (
        .clk   (clk),
        .n_rst (n_rst),
        .en_i  (enable),
        .tick_o(tick)
    );

    // Next position and address; syncs/de decode the next position so they stay aligned with col/row
    always_comb begin
        h_wrap       = col_q == H_LAST;
        v_wrap       = row_q == V_LAST;
        col_d        = !tick ? col_q : h_wrap ? '0 : col_q + CNT_W'(1);
        row_d        = !(tick && h_wrap) ? row_q : v_wrap ? '0 : row_q + CNT_W'(1);
        addr_d       = !tick ? addr_q : (h_wrap && v_wrap) ? '0 : sync_q.de ? addr_q + ADDR_W'(1) : addr_q;
        sync_d.hsync = (col_d >= HS_FIRST && col_d <= HS_LAST) ? HS_POL : ~HS_POL;
        sync_d.vsync = (row_d >= VS_FIRST && row_d <= VS_LAST) ? VS_POL : ~VS_POL;
        sync_d.de    = (col_d < H_ACT) && (row_d < V_ACT);
    end

    // Position, address and sync bundle registers; origin is inside the active region
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            sync_q <= '{hsync: ~HS_POL, vsync: ~VS_POL, de: 1'b1};
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
            sync_q <= sync_d;
        end
    end

    assign pixel_tick = tick;
    assign col        = col_q;
    assign row        = row_q;
    assign addr       = addr_q;
    assign hsync      = sync_q.hsync;
    assign vsync      = sync_q.vsync;
    assign de         = sync_q.de;
    assign line_end   = tick & h_wrap;
    assign frame_end  = line_end & v_wrap;

`ifdef VTG_FRAME_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    // Frame counter advances on each frame pulse and wraps at 16 bits
    always_comb begin
        fcnt_d = frame_end ? fcnt_q + 16'd1 : fcnt_q;
    end

    // Frame counter register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of video_timing_gen on default, mid-size and tiny geometries
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       rst_a_n, en_a, tick_a, hs_a, vs_a, de_a, le_a, fe_a;
    logic [9:0] col_a, row_a;
    logic [19:0] addr_a;
    logic       rst_m_n, en_m, tick_m, hs_m, vs_m, de_m, le_m, fe_m;
    logic [9:0] col_m, row_m;
    logic [19:0] addr_m;
    logic       rst_s_n, en_s, tick_s, hs_s, vs_s, de_s, le_s, fe_s;
    logic [9:0] col_s, row_s;
    logic [19:0] addr_s;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] fc_a, fc_m, fc_s;
`endif

    video_timing_gen u_def (
        .clk(clk), .n_rst(rst_a_n), .enable(en_a), .pixel_tick(tick_a),
        .col(col_a), .row(row_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .addr(addr_a), .line_end(le_a), .frame_end(fe_a)
`ifdef VTG_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    video_timing_gen #(
        .PIX_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_mid (
        .clk(clk), .n_rst(rst_m_n), .enable(en_m), .pixel_tick(tick_m),
        .col(col_m), .row(row_m), .hsync(hs_m), .vsync(vs_m), .de(de_m),
        .addr(addr_m), .line_end(le_m), .frame_end(fe_m)
`ifdef VTG_FRAME_CNT_EN
        , .frame_cnt(fc_m)
`endif
    );

    video_timing_gen #(
        .PIX_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_small (
        .clk(clk), .n_rst(rst_s_n), .enable(en_s), .pixel_tick(tick_s),
        .col(col_s), .row(row_s), .hsync(hs_s), .vsync(vs_s), .de(de_s),
        .addr(addr_s), .line_end(le_s), .frame_end(fe_s)
`ifdef VTG_FRAME_CNT_EN
        , .frame_cnt(fc_s)
`endif
    );

    typedef struct {
        int run, en, tick, col, row, hs, vs, de, addr, le, fe;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n falling edges, then sample just after
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] pk(input logic t, input logic l, input logic f, input logic h,
                                       input logic v, input logic d, input logic [9:0] r, input logic [9:0] c);
        return {6'd0, t, l, f, h, v, d, r, c};
    endfunction

    initial begin
        vec_t vt [15];
        int   p, q, r, c, ea, fe_cnt, le_cnt, tk_cnt, fe_first, fe_second;
        logic et, el, ef, eh, ev, ed;

        vt[0]  = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vt[1]  = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        vt[2]  = '{4, 1, 1, 4, 0, 0, 0, 0, 4, 0, 0};
        vt[3]  = '{1, 1, 1, 5, 0, 1, 0, 0, 4, 0, 0};
        vt[4]  = '{1, 1, 1, 6, 0, 0, 0, 0, 4, 1, 0};
        vt[5]  = '{1, 1, 1, 0, 1, 0, 0, 1, 4, 0, 0};
        vt[6]  = '{3, 1, 1, 3, 1, 0, 0, 1, 7, 0, 0};
        vt[7]  = '{10, 1, 1, 6, 2, 0, 0, 0, 8, 1, 0};
        vt[8]  = '{1, 1, 1, 0, 3, 0, 1, 0, 8, 0, 0};
        vt[9]  = '{13, 1, 1, 6, 4, 0, 0, 0, 8, 1, 1};
        vt[10] = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        vt[11] = '{3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vt[12] = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        vt[13] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0};
        vt[14] = '{5, 1, 1, 6, 0, 0, 0, 0, 4, 1, 0};

        rst_a_n = 1'b0; rst_m_n = 1'b0; rst_s_n = 1'b0;
        en_a = 1'b1; en_m = 1'b1; en_s = 1'b1;
        cyc(2);

        chk("def.reset_state", pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
            pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0));
        chk("def.reset_addr", 32'(addr_a), 0);

        // One full default line plus the first pixel of the next
        rst_a_n = 1'b1;
        for (int n = 1; n <= 1601; n++) begin
            cyc(1);
            p  = (n - 1) / 2;
            c  = p % 800;
            r  = p / 800;
            et = (n % 2 == 0);
            eh = !(c >= 656 && c <= 751);
            ed = (c < 640) && (r < 480);
            el = et && (c == 799);
            ea = r * 640 + ((c < 640) ? c : 640);
            chk($sformatf("def.line[%0d]", n), pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
                pk(et, el, 1'b0, eh, 1'b1, ed, 10'(r), 10'(c)));
            chk($sformatf("def.line_addr[%0d]", n), 32'(addr_a), ea);
        end

        // Freeze at col 100 for 37 clocks
        rst_a_n = 1'b0;
        cyc(1);
        rst_a_n = 1'b1;
        cyc(201);
        chk("def.pre_freeze", pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
            pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd100));
        en_a = 1'b0;
        for (int n = 0; n < 37; n++) begin
            cyc(1);
            chk($sformatf("def.freeze[%0d]", n), pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
                pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd100));
            chk($sformatf("def.freeze_addr[%0d]", n), 32'(addr_a), 100);
        end
        en_a = 1'b1;
        cyc(1);
        chk("def.resume_tick", pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
            pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd100));
        cyc(1);
        chk("def.resume_col", pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
            pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd101));
        chk("def.resume_addr", 32'(addr_a), 101);

        // Asynchronous reset mid-line at col 400 with a tick pending
        rst_a_n = 1'b0;
        cyc(1);
        rst_a_n = 1'b1;
        cyc(802);
        chk("def.pre_reset", pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
            pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd400));
        rst_a_n = 1'b0;
        #1;
        chk("def.async_reset", pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
            pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0));
        chk("def.async_reset_addr", 32'(addr_a), 0);
        cyc(1);
        rst_a_n = 1'b1;
        cyc(1);
        chk("def.restart_1", pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
            pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0));
        cyc(1);
        chk("def.restart_2", pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
            pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0));
        cyc(1);
        chk("def.restart_3", pk(tick_a, le_a, fe_a, hs_a, vs_a, de_a, row_a, col_a),
            pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd1));
        chk("def.restart_addr", 32'(addr_a), 1);

        // Full frame on 15x9 geometry, divide by 2: 270 clocks per frame
        rst_m_n = 1'b1;
        fe_cnt  = 0;
        for (int n = 1; n <= 272; n++) begin
            cyc(1);
            p  = (n - 1) / 2;
            q  = p % 135;
            r  = q / 15;
            c  = q % 15;
            et = (n % 2 == 0);
            eh = !(c >= 10 && c <= 12);
            ev = !(r >= 5 && r <= 6);
            ed = (c < 8) && (r < 4);
            el = et && (c == 14);
            ef = el && (r == 8);
            ea = (r < 4) ? r * 8 + ((c < 8) ? c : 8) : 32;
            if (fe_m) fe_cnt++;
            chk($sformatf("mid.frame[%0d]", n), pk(tick_m, le_m, fe_m, hs_m, vs_m, de_m, row_m, col_m),
                pk(et, el, ef, eh, ev, ed, 10'(r), 10'(c)));
            chk($sformatf("mid.frame_addr[%0d]", n), 32'(addr_m), ea);
        end
        chk("mid.frame_end_count", fe_cnt, 1);

        // Tiny geometry, divide by 1, positive sync polarity
        rst_s_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            en_s = (vt[i].en != 0);
            cyc(vt[i].run);
            chk($sformatf("sm[%0d].tick", i), 32'(tick_s), vt[i].tick);
            chk($sformatf("sm[%0d].col", i), 32'(col_s), vt[i].col);
            chk($sformatf("sm[%0d].row", i), 32'(row_s), vt[i].row);
            chk($sformatf("sm[%0d].hsync", i), 32'(hs_s), vt[i].hs);
            chk($sformatf("sm[%0d].vsync", i), 32'(vs_s), vt[i].vs);
            chk($sformatf("sm[%0d].de", i), 32'(de_s), vt[i].de);
            chk($sformatf("sm[%0d].addr", i), 32'(addr_s), vt[i].addr);
            chk($sformatf("sm[%0d].line_end", i), 32'(le_s), vt[i].le);
            chk($sformatf("sm[%0d].frame_end", i), 32'(fe_s), vt[i].fe);
        end

        // Pulse cadence over 70 clocks: line every 7, frame every 35
        le_cnt = 0; fe_cnt = 0; tk_cnt = 0; fe_first = -1; fe_second = -1;
        for (int n = 0; n < 70; n++) begin
            cyc(1);
            if (tick_s) tk_cnt++;
            if (le_s) le_cnt++;
            if (fe_s) begin
                fe_cnt++;
                if (fe_first < 0) fe_first = n;
                else if (fe_second < 0) fe_second = n;
            end
        end
        chk("sm.tick_count", tk_cnt, 70);
        chk("sm.line_end_count", le_cnt, 10);
        chk("sm.frame_end_count", fe_cnt, 2);
        chk("sm.frame_end_spacing", fe_second - fe_first, 35);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
